// File: rtl/mux_8to1_rr_arbiter_if.sv
// Request/data/grant bundle between the eight requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface mux_8to1_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;

    modport master (
        output req,
        output d,
        input  gnt,
        input  sel,
        input  busy,
        input  y
    );

    modport slave (
        input  req,
        input  d,
        output gnt,
        output sel,
        output busy,
        output y
    );
endinterface

// File: rtl/mux_8to1_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing a single-bit channel through an
// 8-to-1 mux; a hold counter forces rotation when a holder starves contending requesters.

module mux_8to1 (
    input  logic [7:0] i_data,
    input  logic [2:0] s,
    output logic       y
);
    assign y = i_data[s];
endmodule

module mux_8to1_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mux_8to1_rr_arbiter_if.slave       bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    // First set bit of r searching from+1, from+2, ... wrapping; from itself is checked last.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] from);
        logic [2:0] p;
        logic [2:0] idx;
        p = from;
        for (int k = 8; k >= 1; k--) begin
            idx = from + 3'(k);
            if (r[idx]) p = idx;
        end
        return p;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] last_q,  last_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [7:0] gnt_q,   gnt_d;
    logic [2:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;

    logic [7:0] others;
    logic [7:0] pick_src;
    logic [2:0] nxt;
    logic       do_grant;
    logic       mux_y;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        do_grant = 1'b0;
        pick_src = bus.req;
        nxt      = 3'd0;
        others   = bus.req & ~(8'h01 << last_q);

        case (state_q)
            IDLE: begin
                if (|bus.req) do_grant = 1'b1;
            end
            GRANT: begin
                if (!bus.req[last_q]) begin
                    // Release wins over timeout; hand off in the same edge if anyone waits.
                    if (|others) begin
                        do_grant = 1'b1;
                        pick_src = others;
                    end else begin
                        gnt_d   = 8'h00;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (|others) begin
                    if (cnt_q == HOLD_LAST) begin
                        do_grant = 1'b1;
                        pick_src = others;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            nxt     = rr_pick(pick_src, last_q);
            gnt_d   = 8'h01 << nxt;
            sel_d   = nxt;
            busy_d  = 1'b1;
            last_d  = nxt;
            cnt_d   = 4'd0;
            state_d = GRANT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            cnt_q   <= 4'd0;
            gnt_q   <= 8'h00;
            sel_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    mux_8to1 u_mux (
        .i_data (bus.d),
        .s      (sel_q),
        .y      (mux_y)
    );

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.y    = mux_y & busy_q;

endmodule
